// File: rtl/ws2812_pkg.sv
// Shared timing defaults, counter widths and state encoding for the WS2812 serial encoder.
package ws2812_pkg;

   localparam int T0H_DEF    = 8;
   localparam int T1H_DEF    = 16;
   localparam int TBIT_DEF   = 25;
   localparam int TLATCH_DEF = 6000;

   localparam int PIX_W  = 24;
   localparam int CYC_W  = 5;
   localparam int LCNT_W = 13;
   localparam int BCNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_LATCH = 2'd3
   } ws_state_e;

   // Terminal count of a pulse phase, chosen by the bit currently on the wire.
   function automatic logic [CYC_W-1:0] phase_last(input logic msb_v,
                                                   input logic [CYC_W-1:0] one_v,
                                                   input logic [CYC_W-1:0] zero_v);
      return msb_v ? one_v : zero_v;
   endfunction

endpackage

// File: rtl/ws2812_encoder_if.sv
// Pixel-word handshake between an upstream frame source and the WS2812 encoder.
interface ws2812_encoder_if;
   import ws2812_pkg::*;

   logic [PIX_W-1:0] data_in;
   logic             valid;
   logic             latch;
   logic             ready;

   modport master (output data_in, valid, latch, input ready);
   modport slave  (input data_in, valid, latch, output ready);

endinterface

// File: rtl/ws2812_encoder.sv
// Serialises 24-bit pixel words MSB first onto a WS2812 data line, with an
// optional low latch gap after the last word of a frame.
module ws2812_encoder
   import ws2812_pkg::*;
#(
   parameter int T0H    = T0H_DEF,
   parameter int T1H    = T1H_DEF,
   parameter int TBIT   = TBIT_DEF,
   parameter int TLATCH = TLATCH_DEF
) (
   input  logic             clk20,
   input  logic             reset,
   ws2812_encoder_if.slave  bus,
   output logic             led
);

   localparam logic [CYC_W-1:0]  T0H_LAST    = CYC_W'(T0H - 1);
   localparam logic [CYC_W-1:0]  T1H_LAST    = CYC_W'(T1H - 1);
   localparam logic [CYC_W-1:0]  T0L_LAST    = CYC_W'(TBIT - T0H - 1);
   localparam logic [CYC_W-1:0]  T1L_LAST    = CYC_W'(TBIT - T1H - 1);
   localparam logic [LCNT_W-1:0] TLATCH_LAST = LCNT_W'(TLATCH - 1);
   localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(PIX_W - 1);

   ws_state_e         state_r, state_nxt_s;
   logic [CYC_W-1:0]  cyc_cnt_r, cyc_cnt_nxt_s;
   logic [LCNT_W-1:0] lat_cnt_r, lat_cnt_nxt_s;
   logic [BCNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
   logic [PIX_W-1:0]  shift_r, shift_nxt_s;
   logic              latch_flag_r, latch_flag_nxt_s;
   logic              ready_r, ready_nxt_s;
   logic              led_r, led_nxt_s;
   logic [CYC_W-1:0]  high_last_s, low_last_s;

   // Phase lengths of the bit currently at the top of the shift register.
   always_comb begin
      high_last_s = phase_last(shift_r[PIX_W-1], T1H_LAST, T0H_LAST);
      low_last_s  = phase_last(shift_r[PIX_W-1], T1L_LAST, T0L_LAST);
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt_s      = state_r;
      cyc_cnt_nxt_s    = cyc_cnt_r;
      lat_cnt_nxt_s    = lat_cnt_r;
      bit_cnt_nxt_s    = bit_cnt_r;
      shift_nxt_s      = shift_r;
      latch_flag_nxt_s = latch_flag_r;
      ready_nxt_s      = ready_r;
      led_nxt_s        = led_r;

      case (state_r)
         ST_IDLE: begin
            if (bus.valid && ready_r) begin
               shift_nxt_s      = bus.data_in;
               latch_flag_nxt_s = bus.latch;
               ready_nxt_s      = 1'b0;
               led_nxt_s        = 1'b1;
               bit_cnt_nxt_s    = {BCNT_W{1'b0}};
               cyc_cnt_nxt_s    = {CYC_W{1'b0}};
               state_nxt_s      = ST_HIGH;
            end else begin
               ready_nxt_s = 1'b1;
               led_nxt_s   = 1'b0;
            end
         end
         ST_HIGH: begin
            if (cyc_cnt_r == high_last_s) begin
               cyc_cnt_nxt_s = {CYC_W{1'b0}};
               led_nxt_s     = 1'b0;
               state_nxt_s   = ST_LOW;
            end else begin
               cyc_cnt_nxt_s = cyc_cnt_r + 5'd1;
            end
         end
         ST_LOW: begin
            if (cyc_cnt_r == low_last_s) begin
               cyc_cnt_nxt_s = {CYC_W{1'b0}};
               if (bit_cnt_r != LAST_BIT) begin
                  shift_nxt_s   = {shift_r[PIX_W-2:0], 1'b0};
                  bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                  led_nxt_s     = 1'b1;
                  state_nxt_s   = ST_HIGH;
               end else if (latch_flag_r) begin
                  lat_cnt_nxt_s = {LCNT_W{1'b0}};
                  state_nxt_s   = ST_LATCH;
               end else begin
                  ready_nxt_s = 1'b1;
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               cyc_cnt_nxt_s = cyc_cnt_r + 5'd1;
            end
         end
         ST_LATCH: begin
            if (lat_cnt_r == TLATCH_LAST) begin
               lat_cnt_nxt_s = {LCNT_W{1'b0}};
               ready_nxt_s   = 1'b1;
               state_nxt_s   = ST_IDLE;
            end else begin
               lat_cnt_nxt_s = lat_cnt_r + 13'd1;
            end
         end
         default: begin
            ready_nxt_s = 1'b1;
            led_nxt_s   = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk20 or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Counters, shift register, frame flag and registered outputs.
   always_ff @(posedge clk20 or posedge reset) begin
      if (reset) begin
         cyc_cnt_r    <= {CYC_W{1'b0}};
         lat_cnt_r    <= {LCNT_W{1'b0}};
         bit_cnt_r    <= {BCNT_W{1'b0}};
         shift_r      <= {PIX_W{1'b0}};
         latch_flag_r <= 1'b0;
         ready_r      <= 1'b1;
         led_r        <= 1'b0;
      end else begin
         cyc_cnt_r    <= cyc_cnt_nxt_s;
         lat_cnt_r    <= lat_cnt_nxt_s;
         bit_cnt_r    <= bit_cnt_nxt_s;
         shift_r      <= shift_nxt_s;
         latch_flag_r <= latch_flag_nxt_s;
         ready_r      <= ready_nxt_s;
         led_r        <= led_nxt_s;
      end
   end

   assign bus.ready = ready_r;
   assign led       = led_r;

endmodule

// File: doc/ws2812_encoder.md
WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 SHALL have parameter T0H, default 8: clk20 cycles that led is high for a 0 bit (400 ns).
REQ-002 SHALL have parameter T1H, default 16: clk20 cycles that led is high for a 1 bit (800 ns).
REQ-003 SHALL have parameter TBIT, default 25: total clk20 cycles per bit (1.25 us).
REQ-004 SHALL have parameter TLATCH, default 6000: clk20 cycles of led low for a strip latch (300 us).
REQ-005 SHALL have port clk20, input, 1: the single 20 MHz clock; all state is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port data_in, input, 24: pixel word, transmitted MSB (bit 23) first with no reordering.
REQ-008 SHALL have port valid, input, 1: upstream offers data_in/latch.
REQ-009 SHALL have port latch, input, 1: the word is the last of a frame; a latch gap follows it.
REQ-010 SHALL have port ready, output, 1: registered; high only in IDLE.
REQ-011 SHALL have port led, output, 1: registered serial line to the LED strip.

Function
REQ-012 SHALL implement states IDLE, HIGH, LOW and LATCH.
REQ-013 Accept SHALL occur on a clk20 edge where valid=1 and ready=1; at that edge: data_in goes to a 24-bit shift register, latch goes to a flag, ready<=0, led<=1, state<=HIGH, bit count<=0.
REQ-014 HIGH SHALL last T1H cycles if the current MSB is 1, else T0H cycles (led=1), then go to LOW with led<=0.
REQ-015 LOW SHALL last TBIT minus the HIGH length (17 or 9 cycles, led=0); every bit therefore spans exactly TBIT cycles.
REQ-016 At the end of LOW for bits 0..22 the block SHALL shift left by 1, increment the bit count, set led<=1 and enter HIGH.
REQ-017 At the end of LOW for bit 23: latch flag=0 SHALL give IDLE with ready<=1; latch flag=1 SHALL give LATCH.
REQ-018 LATCH SHALL hold led=0 for TLATCH cycles, then go to IDLE with ready<=1.
REQ-019 Word latency SHALL be 24*TBIT = 600 cycles from accept to ready=1, or 600+TLATCH = 6600 cycles with latch.
REQ-020 valid and data_in SHALL be ignored while ready=0; the word in flight SHALL NOT be disturbed.
REQ-021 valid held high across IDLE SHALL cause an immediate re-accept (back-to-back words); the idle gap SHALL extend only the led-low time.
REQ-022 In IDLE led SHALL be 0; upstream gaps under TLATCH SHALL be legal and SHALL NOT be treated as a latch.
REQ-023 Cycle counter SHALL be 5 bits, latch counter 13 bits, bit counter 5 bits; no counter SHALL wrap in a legal sequence.

Reset
REQ-024 While reset=1, without a clock edge: led=0, ready=1, state=IDLE, all counters, shift register and latch flag=0.
REQ-025 Reset mid-word or mid-latch SHALL abandon the transfer; no residual bits SHALL be sent after release.
REQ-026 The first accept SHALL be possible on the first clk20 edge after reset deasserts.

Structure
REQ-027 Timing constants (T0H, T1H, TBIT, TLATCH defaults) and the state encoding SHALL live in shared package ws2812_pkg.
REQ-028 No sub-module SHALL be used; counters and the shift register are inline in ws2812_encoder.

Verification
REQ-029 Accept 24'hFF0000, latch=0 -> eight pulses high 16/low 9, sixteen pulses high 8/low 17; ready=1 exactly 600 cycles after accept.
REQ-030 Accept 24'h000001, latch=1 -> last pulse high 16, then led low 9+6000 cycles; ready=1 at accept+6600.
REQ-031 Accept 24'hAAAAAA, then assert valid with 24'h555555 at accept+100 -> decoded stream is still AAAAAA; 555555 is accepted only after ready rises.
REQ-032 Assert reset at accept+37 (mid-bit 1 HIGH) -> led=0 before the next edge; after release ready=1 and led stays 0 until the next accept.
REQ-033 Controller-style handshake (wait ready, valid=1, wait !ready, valid=0, 1-cycle load gap), 140 random words, last with latch=1 -> 3360 decoded bits match, each bit 25 cycles plus any gap, and one 6000-cycle latch.
REQ-034 valid held high with 3 words queued by the bench -> ready is high exactly one cycle between words; word period is 601 cycles.
